tmds_encoder: RTL
=================

Name: tmds_encoder

Overview:
- DVI/HDMI TMDS 8b/10b channel encoder with a 2-stage pipeline.
- One instance per colour channel.
- Sits directly upstream of the 10:1 serializer. Its 10-bit symbol feeds the serializer's parallel input in the pixel clock domain.
- o_tmds[0] is the first bit transmitted on the wire.

Parameters:
- RESET_SYMBOL, 10'b1101010100, value of o_tmds during and immediately after reset (control symbol for ctrl=00).

Ports:
- i_clk  input  1  pixel clock (same clock as the serializer's parallel clock)
- i_rst_n  input  1  asynchronous reset, active low
- i_de  input  1  data enable: 1 = video data period, 0 = control period
- i_data  input  8  pixel component, sampled when i_de=1
- i_ctrl  input  2  control bits {C1,C0}, sampled when i_de=0
- o_tmds  output  10  encoded TMDS symbol, registered
- o_de  output  1  i_de delayed to align with o_tmds

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While i_rst_n=0, all pipeline registers clear asynchronously: o_tmds=RESET_SYMBOL, o_de=0, disparity counter cnt=0, stage-1 de=0, stage-1 ctrl=00.
  - Release is synchronous to i_clk. The first valid symbol appears 2 cycles after the first post-release input sample.
  - Reset asserted mid-stream discards in-flight symbols. No partial symbol is ever output.
- Latency: exactly 2 i_clk cycles from the input sample to o_tmds/o_de. Throughput is one symbol per cycle with no stalls.
- Stage 1 (transition minimisation), registered:
  - n1d = popcount(i_data), 4 bits.
  - XNOR mode if n1d>4, or n1d==4 and i_data[0]==0. Otherwise XOR mode.
  - q_m[0]=i_data[0]; q_m[i]=q_m[i-1] XOR/XNOR i_data[i] for i=1..7.
  - q_m[8]=1 in XOR mode, 0 in XNOR mode.
  - Register q_m[8:0], n1q=popcount(q_m[7:0]), de, ctrl.
- Stage 2 (DC balance):
  - cnt is a 5-bit signed running disparity. n0q=8-n1q.
  - If de=0: o_tmds is the control symbol and cnt<=0.
    - ctrl 00 -> 10'b1101010100
    - ctrl 01 -> 10'b0010101011
    - ctrl 10 -> 10'b0101010100
    - ctrl 11 -> 10'b1010101011
  - Else if cnt==0 or n1q==n0q:
    - o_tmds={~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (n1q-n0q) : (n0q-n1q).
  - Else if (cnt>0 and n1q>n0q) or (cnt<0 and n0q>n1q):
    - o_tmds={1'b1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + (n0q-n1q).
  - Else:
    - o_tmds={1'b0, q_m[8], q_m[7:0]}.
    - cnt += (n1q-n0q) - 2*(~q_m[8]).
- Arithmetic width:
  - All disparity arithmetic is done signed at ≥6 bits, then truncated to 5 bits.
  - cnt is always even and stays within [-8,+8]. Assertions check this.
- DE edges:
  - Control→data: the first data symbol is encoded with cnt=0, because the control period cleared it.
  - Data→control: takes effect on the next symbol with no gap cycle.
  - i_ctrl is ignored when i_de=1. i_data is ignored when i_de=0.

Decomposition:
- Shared package tmds_pkg holds:
  - CTRL_SYM[4] array of 10-bit control symbols.
  - localparam TMDS_LATENCY=2.
  - typedef logic signed [4:0] disparity_t.
  - function popcount8.
- No sub-module. The two stages live in one module. Other channel instances and the serializer reuse tmds_pkg.

Test Plan:
- Reset: hold i_rst_n=0 and toggle inputs -> o_tmds=10'h354 and o_de=0 throughout. Release, then drive de=0, ctrl=01 -> o_tmds=10'h0AB exactly 2 cycles later.
- All four ctrl codes with de=0 -> 10'h354, 10'h0AB, 10'h154, 10'h2AB in order, each at latency 2.
- de=1, i_data=0x00 for 4 cycles starting from cnt=0 -> o_tmds sequence 10'h100, 10'h3FF, 10'h100, 10'h3FF, with internal cnt sequence -8, 2, -6, 4.
- de=1, i_data=0xFF from cnt=0 -> o_tmds=10'h200 and cnt=-8. Then 0x00, 2 cycles of de=0, then 0x00 -> the last symbol is 10'h100, showing the control period cleared cnt.
- Random 10k pixels with random de -> every o_tmds matches the reference-model encoding. Decoding o_tmds recovers i_data. cnt stays in [-8,8]. o_de equals i_de delayed by 2.
- Assert i_rst_n low mid-stream, asynchronously and between clock edges -> o_tmds=10'h354 immediately. The next 2 post-release outputs come only from post-release inputs.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control symbols, pipeline latency, disparity type and popcount.
// Used by every channel encoder instance and by the serializer.
package tmds_pkg;

  localparam int unsigned TMDS_LATENCY = 2;

  typedef logic signed [4:0] disparity_t;

  // Indexed by {C1,C0}
  localparam logic [9:0] CTRL_SYM [4] = '{
    10'b1101010100,
    10'b0010101011,
    10'b0101010100,
    10'b1010101011
  };

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_encoder.sv
// DVI/HDMI TMDS 8b/10b channel encoder, two-stage pipeline: transition minimisation,
// then DC balance against a running disparity.
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter logic [9:0] RESET_SYMBOL = 10'b1101010100
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_de,
  input  logic [7:0] i_data,
  input  logic [1:0] i_ctrl,
  output logic [9:0] o_tmds,
  output logic       o_de
);

  logic [3:0] n1d;
  logic       use_xnor;
  logic [8:0] qm_d;

  logic [8:0] qm_q;
  logic [3:0] n1q_q;
  logic       de1_q;
  logic [1:0] ctrl1_q;

  disparity_t cnt_q, cnt_d;
  logic [9:0] tmds_q, tmds_d;
  logic       de_q;

  always_comb begin
    n1d      = popcount8(i_data);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !i_data[0]);
    qm_d     = '0;
    qm_d[0]  = i_data[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ i_data[i]) : (qm_d[i-1] ^ i_data[i]);
    end
    qm_d[8] = ~use_xnor;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      qm_q    <= '0;
      n1q_q   <= '0;
      de1_q   <= 1'b0;
      ctrl1_q <= 2'b00;
    end else begin
      qm_q    <= qm_d;
      n1q_q   <= popcount8(qm_d[7:0]);
      de1_q   <= i_de;
      ctrl1_q <= i_ctrl;
    end
  end

  // Disparity math is done at 6 bits signed so intermediate sums cannot wrap.
  logic signed [5:0] n1s, n0s, diff, cnt_ext, qm8_x2, nqm8_x2, sum;

  always_comb begin
    n1s     = $signed({2'b00, n1q_q});
    n0s     = 6'sd8 - n1s;
    diff    = n1s - n0s;
    cnt_ext = {cnt_q[4], cnt_q};
    qm8_x2  = qm_q[8] ? 6'sd2 : 6'sd0;
    nqm8_x2 = qm_q[8] ? 6'sd0 : 6'sd2;
    sum     = 6'sd0;
    tmds_d  = CTRL_SYM[ctrl1_q];
    if (!de1_q) begin
      sum = 6'sd0;
    end else if ((cnt_q == 5'sd0) || (diff == 6'sd0)) begin
      tmds_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
      sum    = qm_q[8] ? (cnt_ext + diff) : (cnt_ext - diff);
    end else if (((cnt_q > 5'sd0) && (diff > 6'sd0)) || ((cnt_q < 5'sd0) && (diff < 6'sd0))) begin
      tmds_d = {1'b1, qm_q[8], ~qm_q[7:0]};
      sum    = cnt_ext + qm8_x2 - diff;
    end else begin
      tmds_d = {1'b0, qm_q[8], qm_q[7:0]};
      sum    = cnt_ext + diff - nqm8_x2;
    end
    cnt_d = sum[4:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmds_q <= RESET_SYMBOL;
      de_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      tmds_q <= tmds_d;
      de_q   <= de1_q;
      cnt_q  <= cnt_d;
    end
  end

  assign o_tmds = tmds_q;
  assign o_de   = de_q;

  cnt_range_a: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (cnt_q >= -5'sd8) && (cnt_q <= 5'sd8) && !cnt_q[0]);

endmodule
